// File: rtl/reg_write_tracer.sv
// Register-file write monitor: shadow copy plus a FIFO of write trace records.
// Define TRACE_PC_EN to add trace_pc and store P_C with each record.
module reg_write_tracer #(
    parameter int          NUM_PORTS  = 2,
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 5,
    parameter int          PC_W       = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter int unsigned PC_START   = 12
) (
    input  logic                        reloj,
    input  logic                        resetM,
    input  logic [PC_W-1:0]             P_C,
    input  logic [NUM_PORTS-1:0]        wr_n,
    input  logic [NUM_PORTS*ADDR_W-1:0] wr_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]           sh_addr,
    output logic [DATA_W-1:0]           sh_data,
    output logic                        trace_valid,
    input  logic                        trace_ready,
    output logic [1:0]                  trace_port,
    output logic [ADDR_W-1:0]           trace_addr,
    output logic [DATA_W-1:0]           trace_data,
`ifdef TRACE_PC_EN
    output logic [PC_W-1:0]             trace_pc,
`endif
    output logic                        overflow,
    output logic [7:0]                  drop_cnt
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [1:0]        port;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
`ifdef TRACE_PC_EN
        logic [PC_W-1:0]   pc;
`endif
    } rec_t;

    logic [DATA_W-1:0]    shadow [2**ADDR_W];
    rec_t                 fifo_mem [FIFO_DEPTH];
    rec_t                 rec_in [NUM_PORTS];
    rec_t                 head;
    logic [PW-1:0]        slot [NUM_PORTS];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count, n, free;
    logic [NUM_PORTS-1:0] qual;
    logic [8:0]           drop_sum;
    logic                 pc_ok, fits, push, pop;

    // Each qualified port takes the next slot after the lower-indexed ones.
    always_comb begin
        pc_ok = (P_C >= PC_W'(PC_START));
        n     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            slot[k]        = wr_ptr + n[PW-1:0];
            qual[k]        = !wr_n[k] && pc_ok &&
                             (wr_addr[k*ADDR_W +: ADDR_W] != '0);
            rec_in[k].port = 2'(k);
            rec_in[k].addr = wr_addr[k*ADDR_W +: ADDR_W];
            rec_in[k].data = wr_data[k*DATA_W +: DATA_W];
`ifdef TRACE_PC_EN
            rec_in[k].pc   = P_C;
`endif
            n = n + CW'(qual[k]);
        end
        free     = CW'(FIFO_DEPTH) - count;
        fits     = (n <= free);
        push     = (n != '0) && fits;
        pop      = trace_valid && trace_ready;
        drop_sum = {1'b0, drop_cnt} + 9'(n);
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            for (int i = 0; i < 2**ADDR_W; i++) shadow[i] <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++)
                if (qual[k])
                    shadow[wr_addr[k*ADDR_W +: ADDR_W]] <=
                        wr_data[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge reloj) begin
        if (push)
            for (int k = 0; k < NUM_PORTS; k++)
                if (qual[k]) fifo_mem[slot[k]] <= rec_in[k];
    end

    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + n[PW-1:0];
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (push ? n : '0) - CW'(pop);
            if ((n != '0) && !fits) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
        end
    end

    assign head        = fifo_mem[rd_ptr];
    assign trace_valid = (count != '0);
    assign trace_port  = head.port;
    assign trace_addr  = head.addr;
    assign trace_data  = head.data;
`ifdef TRACE_PC_EN
    assign trace_pc    = head.pc;
`endif
    assign sh_data     = shadow[sh_addr];

endmodule

// File: tb/tb_reg_write_tracer.sv
// Bench for reg_write_tracer: vector table plus reset/overflow sequences,
// with a queue of expected trace records checked against the FIFO head.
module tb_reg_write_tracer;

    logic        reloj = 1'b0;
    logic        resetM;
    logic [31:0] P_C;
    logic [1:0]  wr_n;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [4:0]  sh_addr;
    logic [31:0] sh_data;
    logic        trace_valid, trace_ready;
    logic [1:0]  trace_port;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic        overflow;
    logic [7:0]  drop_cnt;
`ifdef TRACE_PC_EN
    logic [31:0] trace_pc;
`endif

    reg_write_tracer dut (
        .reloj(reloj), .resetM(resetM), .P_C(P_C),
        .wr_n(wr_n), .wr_addr(wr_addr), .wr_data(wr_data),
        .sh_addr(sh_addr), .sh_data(sh_data),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_port(trace_port), .trace_addr(trace_addr),
        .trace_data(trace_data),
`ifdef TRACE_PC_EN
        .trace_pc(trace_pc),
`endif
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 reloj = ~reloj;

    typedef struct packed {
        logic [1:0]  port;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } rec_t;

    typedef struct {
        logic [1:0]  wn;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [31:0] pc;
        logic        rdy;
        logic [4:0]  sh_a;
        logic [31:0] sh_d;
    } vec_t;

    rec_t exp_q[$];
    vec_t vt[9];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_drop = 0;
    logic m_ovf  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sh_chk(input logic [4:0] a, input logic [31:0] d);
        sh_addr = a;
        #1;
        chk($sformatf("sh_data[%0d]", a), 64'(sh_data), 64'(d));
    endtask

    // Entered and left just after a falling edge.
    task automatic cycle(input logic [1:0] wn, input logic [4:0] a0,
                         input logic [31:0] d0, input logic [4:0] a1,
                         input logic [31:0] d1, input logic [31:0] pc,
                         input logic rdy);
        rec_t        nr[$];
        int          cnt;
        logic [4:0]  aa[2];
        logic [31:0] dd[2];
        aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
        wr_n = wn; wr_addr = {a1, a0}; wr_data = {d1, d0};
        P_C = pc; trace_ready = rdy;
        #1;
        chk("trace_valid", 64'(trace_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("trace_port", 64'(trace_port), 64'(exp_q[0].port));
            chk("trace_addr", 64'(trace_addr), 64'(exp_q[0].addr));
            chk("trace_data", 64'(trace_data), 64'(exp_q[0].data));
`ifdef TRACE_PC_EN
            chk("trace_pc", 64'(trace_pc), 64'(exp_q[0].pc));
`endif
        end
        cnt = exp_q.size();
        for (int k = 0; k < 2; k++)
            if (!wn[k] && pc >= 32'd12 && aa[k] != 5'd0)
                nr.push_back('{port: 2'(k), addr: aa[k], data: dd[k], pc: pc});
        if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
        if (nr.size() <= 8 - cnt) begin
            foreach (nr[i]) exp_q.push_back(nr[i]);
        end else begin
            m_ovf  = 1'b1;
            m_drop = (m_drop + nr.size() > 255) ? 255 : m_drop + nr.size();
        end
        @(posedge reloj);
        @(negedge reloj);
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic do_reset();
        resetM = 1'b1;
        wr_n = 2'b11; wr_addr = '0; wr_data = '0;
        P_C = '0; trace_ready = 1'b0; sh_addr = '0;
        repeat (3) @(negedge reloj);
        chk("rst trace_valid", 64'(trace_valid), 64'd0);
        chk("rst overflow", 64'(overflow), 64'd0);
        chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
        exp_q.delete();
        m_ovf = 1'b0;
        m_drop = 0;
        resetM = 1'b0;
    endtask

    initial begin
        vt[0] = '{2'b10, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 32'd8, 1'b0, 5'd3, 32'h0};
        vt[1] = '{2'b10, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0, 32'd12, 1'b0, 5'd3, 32'hDEADBEEF};
        vt[2] = '{2'b00, 5'd5, 32'h11, 5'd5, 32'h22, 32'd12, 1'b0, 5'd5, 32'h22};
        vt[3] = '{2'b10, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 32'd40, 1'b0, 5'd0, 32'h0};
        vt[4] = '{2'b01, 5'd9, 32'h99, 5'd7, 32'h77, 32'd13, 1'b0, 5'd9, 32'h0};
        vt[5] = '{2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 32'd13, 1'b0, 5'd7, 32'h77};
        vt[6] = '{2'b00, 5'd8, 32'h8, 5'd9, 32'h9, 32'd11, 1'b0, 5'd8, 32'h0};
        vt[7] = '{2'b00, 5'd10, 32'hA, 5'd0, 32'hB, 32'hFFFFFFF0, 1'b0, 5'd10, 32'hA};
        vt[8] = '{2'b11, 5'd0, 32'h0, 5'd0, 32'h0, 32'd20, 1'b1, 5'd5, 32'h22};

        @(negedge reloj);
        do_reset();
        for (int a = 0; a < 32; a++) begin
            @(negedge reloj);
            sh_chk(5'(a), 32'h0);
        end
        @(negedge reloj);

        for (int i = 0; i < 9; i++) begin
            cycle(vt[i].wn, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1,
                  vt[i].pc, vt[i].rdy);
            sh_chk(vt[i].sh_a, vt[i].sh_d);
        end
        for (int i = 0; i < 10; i++)
            cycle(2'b11, 5'd0, 32'h0, 5'd0, 32'h0, 32'd20, 1'b1);
        chk("drained valid", 64'(trace_valid), 64'd0);

        // Fill to 8, then overflow, then a full-with-pop cycle.
        do_reset();
        @(negedge reloj);
        for (int i = 0; i < 4; i++)
            cycle(2'b00, 5'(1 + 2*i), 32'h100 + 32'(i), 5'(2 + 2*i),
                  32'h200 + 32'(i), 32'd100 + 32'(i), 1'b0);
        cycle(2'b00, 5'd20, 32'h5A5A, 5'd21, 32'hA5A5, 32'd200, 1'b0);
        chk("ovf overflow", 64'(overflow), 64'd1);
        chk("ovf drop_cnt", 64'(drop_cnt), 64'd2);
        chk("ovf valid", 64'(trace_valid), 64'd1);
        sh_chk(5'd21, 32'hA5A5);
        cycle(2'b00, 5'd22, 32'h1, 5'd23, 32'h2, 32'd201, 1'b1);
        chk("no credit drop_cnt", 64'(drop_cnt), 64'd4);
        for (int i = 0; i < 7; i++)
            cycle(2'b11, 5'd0, 32'h0, 5'd0, 32'h0, 32'd0, 1'b1);
        chk("after drain valid", 64'(trace_valid), 64'd0);
        cycle(2'b11, 5'd0, 32'h0, 5'd0, 32'h0, 32'd0, 1'b1);

        // Drop counter saturation.
        do_reset();
        @(negedge reloj);
        for (int i = 0; i < 4; i++)
            cycle(2'b00, 5'd1, 32'(i), 5'd2, 32'(i), 32'd50, 1'b0);
        for (int i = 0; i < 130; i++)
            cycle(2'b00, 5'd3, 32'(i), 5'd4, 32'(i), 32'd50, 1'b0);
        chk("sat drop_cnt", 64'(drop_cnt), 64'd255);

        // Asynchronous reset with records queued.
        do_reset();
        @(negedge reloj);
        cycle(2'b00, 5'd6, 32'h66, 5'd7, 32'h77, 32'd30, 1'b0);
        cycle(2'b10, 5'd8, 32'h88, 5'd0, 32'h0, 32'd31, 1'b0);
        chk("pre-reset valid", 64'(trace_valid), 64'd1);
        #2 resetM = 1'b1;
        #1;
        chk("async reset valid", 64'(trace_valid), 64'd0);
        do_reset();
        chk("post-reset drop_cnt", 64'(drop_cnt), 64'd0);
        sh_chk(5'd6, 32'h0);
        @(negedge reloj);
        cycle(2'b01, 5'd0, 32'h0, 5'd12, 32'hC0FFEE, 32'd12, 1'b0);
        cycle(2'b11, 5'd0, 32'h0, 5'd0, 32'h0, 32'd12, 1'b1);
        cycle(2'b11, 5'd0, 32'h0, 5'd0, 32'h0, 32'd12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
